// File: rtl/psr_cond.sv
// Processor status register with branch-condition evaluator and a small flag save stack.
// Flags are ordered {N, Z, F, L, C}; condition results pulse one cycle after the request.
module psr_cond #(
  parameter int P_STACK_DEPTH = 4
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_ENABLE,
  input  logic       I_STATUS_WE,
  input  logic [4:0] I_STATUS,
  input  logic [3:0] I_COND,
  input  logic       I_COND_REQ,
  input  logic       I_PUSH,
  input  logic       I_POP,
  output logic [4:0] O_FLAGS,
  output logic       O_COND_VALID,
  output logic       O_COND_TRUE,
  output logic       O_FULL,
  output logic       O_EMPTY,
  output logic       O_ERROR
);

  localparam int AW = $clog2(P_STACK_DEPTH);
  localparam int CW = AW + 1;

  localparam int B_C = 0;
  localparam int B_L = 1;
  localparam int B_F = 2;
  localparam int B_Z = 3;
  localparam int B_N = 4;

  logic [4:0]    flags_reg;
  logic [CW-1:0] count_reg;
  logic          valid_reg;
  logic          true_reg;
  logic          error_reg;
  logic [4:0]    stack_mem [P_STACK_DEPTH];

  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop_req;
  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          cond_base;
  logic          cond_result;

  assign full     = (count_reg == CW'(P_STACK_DEPTH));
  assign empty    = (count_reg == '0);
  // A simultaneous push and pop cancel out entirely, including error reporting.
  assign push_req = I_ENABLE & I_PUSH & ~I_POP;
  assign pop_req  = I_ENABLE & I_POP & ~I_PUSH;
  assign push_ok  = push_req & ~full;
  assign pop_ok   = pop_req & ~empty;
  // When full the low bits wrap to 0, so top-of-stack is still wr_addr - 1.
  assign wr_addr  = count_reg[AW-1:0];
  assign rd_addr  = wr_addr - AW'(1);

  // Odd codes are the complement of the preceding even code.
  always_comb begin
    cond_base = 1'b0;
    case (I_COND[3:1])
      3'd0: cond_base = flags_reg[B_Z];
      3'd1: cond_base = flags_reg[B_C];
      3'd2: cond_base = flags_reg[B_L];
      3'd3: cond_base = flags_reg[B_N];
      3'd4: cond_base = flags_reg[B_F];
      3'd5: cond_base = ~flags_reg[B_L] & ~flags_reg[B_Z];
      3'd6: cond_base = ~flags_reg[B_N] & ~flags_reg[B_Z];
      3'd7: cond_base = 1'b1;
      default: cond_base = 1'b0;
    endcase
    cond_result = cond_base ^ I_COND[0];
  end

  always_ff @(posedge I_CLK) begin
    if (push_ok) begin
      stack_mem[wr_addr] <= flags_reg;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      flags_reg <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      true_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      valid_reg <= I_ENABLE & I_COND_REQ;
      if (I_ENABLE && I_COND_REQ) begin
        true_reg <= cond_result;
      end
      if (pop_ok) begin
        flags_reg <= stack_mem[rd_addr];
      end else if (I_ENABLE && I_STATUS_WE) begin
        flags_reg <= I_STATUS;
      end
      if (push_ok) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop_ok) begin
        count_reg <= count_reg - CW'(1);
      end
      if ((push_req && full) || (pop_req && empty)) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign O_FLAGS      = flags_reg;
  assign O_COND_VALID = valid_reg;
  assign O_COND_TRUE  = true_reg;
  assign O_FULL       = full;
  assign O_EMPTY      = empty;
  assign O_ERROR      = error_reg;

endmodule

// File: tb/tb_psr_cond.sv
// Bench for psr_cond: queue-based reference model checked every cycle, plus literal expectations.
module tb_psr_cond;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       we = 1'b0;
  logic [4:0] status = '0;
  logic [3:0] cond = '0;
  logic       req = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [4:0] flags;
  logic       cvalid;
  logic       ctrue;
  logic       full;
  logic       empty;
  logic       err;

  int checks = 0;
  int failures = 0;

  psr_cond #(.P_STACK_DEPTH(DEPTH)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_STATUS_WE(we), .I_STATUS(status),
    .I_COND(cond), .I_COND_REQ(req), .I_PUSH(push), .I_POP(pop), .O_FLAGS(flags),
    .O_COND_VALID(cvalid), .O_COND_TRUE(ctrue), .O_FULL(full), .O_EMPTY(empty), .O_ERROR(err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0] m_flags;
  logic       m_valid;
  logic       m_true;
  logic       m_err;
  logic [4:0] m_stack[$];

  function automatic logic eval_cond(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return lf;
      4'd5:  return !lf;
      4'd6:  return nf;
      4'd7:  return !nf;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !lf && !zf;
      4'd11: return lf || zf;
      4'd12: return !nf && !zf;
      4'd13: return nf || zf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [4:0] old;
    logic popped;
    if (rst) begin
      m_flags = '0; m_valid = 0; m_true = 0; m_err = 0;
      m_stack.delete();
    end else if (!en) begin
      m_valid = 0;
    end else begin
      old = m_flags;
      popped = 0;
      m_valid = req;
      if (req) m_true = eval_cond(cond, old);
      if (push && !pop) begin
        if (m_stack.size() == DEPTH) m_err = 1;
        else m_stack.push_back(old);
      end else if (pop && !push) begin
        if (m_stack.size() == 0) m_err = 1;
        else begin
          m_flags = m_stack.pop_back();
          popped = 1;
        end
      end
      if (we && !popped) m_flags = status;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_flags", {3'b0, flags}, {3'b0, m_flags});
      chk("model_valid", {7'b0, cvalid}, {7'b0, m_valid});
      chk("model_true", {7'b0, ctrue}, {7'b0, m_true});
      chk("model_full", {7'b0, full}, {7'b0, (m_stack.size() == DEPTH)});
      chk("model_empty", {7'b0, empty}, {7'b0, (m_stack.size() == 0)});
      chk("model_error", {7'b0, err}, {7'b0, m_err});
    end
  end

  task automatic step(input logic e, input logic w, input logic [4:0] s, input logic [3:0] c,
                      input logic r, input logic ps, input logic pp);
    en = e; we = w; status = s; cond = c; req = r; push = ps; pop = pp;
    @(posedge clk);
    #2;
    en = 1; we = 0; status = '0; cond = '0; req = 0; push = 0; pop = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_flags"}, {3'b0, flags}, 8'h00);
    chk({tag, "_valid"}, {7'b0, cvalid}, 8'h00);
    chk({tag, "_true"}, {7'b0, ctrue}, 8'h00);
    chk({tag, "_error"}, {7'b0, err}, 8'h00);
    chk({tag, "_empty"}, {7'b0, empty}, 8'h01);
    chk({tag, "_full"}, {7'b0, full}, 8'h00);
  endtask

  task automatic reset_pulse(input string tag);
    #1 rst = 1;
    #1 chk_reset_values(tag);
    rst = 0;
  endtask

  initial begin
    logic [4:0] pats [4];
    pats[0] = 5'b00000; pats[1] = 5'b11111; pats[2] = 5'b01010; pats[3] = 5'b10101;
    #1 chk_reset_values("por");
    @(negedge clk);
    rst = 0;

    // EQ / NE against Z=1, then result holds when no request
    step(1, 1, 5'b01000, 0, 0, 0, 0);
    step(1, 0, 0, 4'd0, 1, 0, 0);
    chk("eq_valid", {7'b0, cvalid}, 8'h01);
    chk("eq_true", {7'b0, ctrue}, 8'h01);
    step(1, 0, 0, 4'd1, 1, 0, 0);
    chk("ne_true", {7'b0, ctrue}, 8'h00);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("idle_valid", {7'b0, cvalid}, 8'h00);

    // GE evaluated on pre-update flags N=1 while writing zero
    step(1, 1, 5'b10000, 0, 0, 0, 0);
    step(1, 1, 5'b00000, 4'd13, 1, 0, 0);
    chk("ge_preupdate_true", {7'b0, ctrue}, 8'h01);
    chk("ge_flags_loaded", {3'b0, flags}, 8'h00);

    // Fill the stack using push + write together
    step(1, 1, 5'b00001, 0, 0, 0, 0);
    step(1, 1, 5'b00010, 0, 0, 1, 0);
    step(1, 1, 5'b00100, 0, 0, 1, 0);
    step(1, 1, 5'b01000, 0, 0, 1, 0);
    step(1, 1, 5'b10000, 0, 0, 1, 0);
    chk("fill_full", {7'b0, full}, 8'h01);
    chk("fill_flags", {3'b0, flags}, 8'h10);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("overflow_error", {7'b0, err}, 8'h01);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("pop1", {3'b0, flags}, 8'h08);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("pop2", {3'b0, flags}, 8'h04);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("pop3", {3'b0, flags}, 8'h02);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("pop4", {3'b0, flags}, 8'h01);
    chk("pop4_empty", {7'b0, empty}, 8'h01);

    // Underflow keeps flags, error is sticky
    step(1, 0, 0, 0, 0, 0, 1);
    chk("underflow_flags", {3'b0, flags}, 8'h01);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    chk("error_sticky", {7'b0, err}, 8'h01);

    step(1, 1, 5'b11111, 4'd14, 1, 0, 0);
    chk("uc_true", {7'b0, ctrue}, 8'h01);
    reset_pulse("rst_mid1");

    // Pop wins over a write; push+pop leaves occupancy alone
    step(1, 1, 5'b00110, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 5'b11111, 0, 0, 0, 1);
    chk("pop_beats_we", {3'b0, flags}, 8'h06);
    step(1, 1, 5'b00011, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    chk("pushpop_empty", {7'b0, empty}, 8'h00);
    chk("pushpop_error", {7'b0, err}, 8'h00);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("pushpop_restore", {3'b0, flags}, 8'h03);
    chk("pushpop_drained", {7'b0, empty}, 8'h01);

    // Sweep every condition code across a few flag patterns, back to back
    foreach (pats[p]) begin
      step(1, 1, pats[p], 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) step(1, 0, 0, c[3:0], 1, 0, 0);
    end

    // Disabled: nothing changes
    step(1, 1, 5'b01100, 0, 0, 0, 0);
    step(0, 1, 5'b10011, 4'd14, 1, 1, 0);
    chk("dis_flags", {3'b0, flags}, 8'h0c);
    chk("dis_valid", {7'b0, cvalid}, 8'h00);
    chk("dis_empty", {7'b0, empty}, 8'h01);

    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 4'd14, 1, 0, 0);
    reset_pulse("rst_mid2");
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psr_cond.md
PSR_COND -- requirements
Module: psr_cond

Interface
REQ-001 SHALL have parameter P_STACK_DEPTH, default 4, meaning the number of flag save slots (power of two, >= 2).
REQ-002 SHALL have port I_CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port I_RESET  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port I_ENABLE  input  1  global enable; when low, every write, push, pop and condition request is ignored.
REQ-005 SHALL have port I_STATUS_WE  input  1  latch I_STATUS into the flag register.
REQ-006 SHALL have port I_STATUS  input  5  ALU status: bit0 Carry, bit1 Low, bit2 Flag, bit3 Zero, bit4 Negative.
REQ-007 SHALL have port I_COND  input  4  branch/jump condition code.
REQ-008 SHALL have port I_COND_REQ  input  1  condition evaluation request.
REQ-009 SHALL have port I_PUSH  input  1  save the current flags to the stack.
REQ-010 SHALL have port I_POP  input  1  restore the flags from the stack.
REQ-011 SHALL have port O_FLAGS  output  5  current flag register, same bit order as I_STATUS.
REQ-012 SHALL have port O_COND_VALID  output  1  one-cycle pulse qualifying O_COND_TRUE.
REQ-013 SHALL have port O_COND_TRUE  output  1  evaluated condition result.
REQ-014 SHALL have ports O_FULL and O_EMPTY  output  1 each  stack occupancy == P_STACK_DEPTH / == 0.
REQ-015 SHALL have port O_ERROR  output  1  sticky push-overflow / pop-underflow indicator.

Function
REQ-016 SHALL, with I_ENABLE=1 and I_STATUS_WE=1, load I_STATUS into O_FLAGS at the next edge (1-cycle latency).
REQ-017 SHALL, on a condition request, present O_COND_VALID=1 and O_COND_TRUE at the next edge for exactly one cycle, evaluated against O_FLAGS as held in the request cycle (pre-update); back-to-back requests yield back-to-back pulses.
REQ-018 SHALL decode I_COND: 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0; 4 HI L=1; 5 LS L=0; 6 GT N=1; 7 LE N=0; 8 FS F=1; 9 FC F=0; 10 LO L=0&Z=0; 11 HS L=1|Z=1; 12 LT N=0&Z=0; 13 GE N=1|Z=1; 14 UC always 1; 15 NV always 0.
REQ-019 SHALL hold O_COND_TRUE at its last value while O_COND_VALID=0.
REQ-020 SHALL, on a push when not full, store the pre-update O_FLAGS in the slot at the stack pointer and increment the pointer.
REQ-021 SHALL, on a pop when not empty, decrement the pointer and load O_FLAGS from that slot at the next edge.
REQ-022 SHALL ignore a push when full (stack and pointer unchanged) and set O_ERROR.
REQ-023 SHALL ignore a pop when empty (O_FLAGS and pointer unchanged) and set O_ERROR.
REQ-024 SHALL clear O_ERROR only by reset.
REQ-025 SHALL treat simultaneous I_PUSH and I_POP as no stack operation and no error.
REQ-026 SHALL give a valid pop priority over I_STATUS_WE in the same cycle (restored value wins).
REQ-027 SHALL, on simultaneous push and I_STATUS_WE, push the old flags and load I_STATUS.
REQ-028 SHALL use an occupancy counter 0..P_STACK_DEPTH with no wrap-around.

Reset
REQ-029 SHALL, while I_RESET=1, force O_FLAGS=5'b00000, O_COND_VALID=0, O_COND_TRUE=0, O_ERROR=0, occupancy=0 (O_EMPTY=1, O_FULL=0) immediately, independent of I_CLK.
REQ-030 SHALL discard any request, push or pop in flight when reset asserts mid-operation; stack slot contents need no reset.

Verification
REQ-031 SHALL cover: write I_STATUS=5'b01000, then request I_COND=0 -> O_COND_VALID pulse, O_COND_TRUE=1; I_COND=1 -> 0.
REQ-032 SHALL cover: request I_COND=13 in the same cycle as write 5'b00000 over flags 5'b10000 -> O_COND_TRUE=1 (pre-update flags used).
REQ-033 SHALL cover: 4 pushes of distinct flags -> O_FULL=1; 5th push -> O_ERROR=1, stack unchanged; 4 pops restore values in reverse order, O_EMPTY=1.
REQ-034 SHALL cover: pop on empty -> O_FLAGS unchanged, O_ERROR=1 and stays 1 until reset.
REQ-035 SHALL cover: pop plus I_STATUS_WE=1 with I_STATUS=5'b11111 -> O_FLAGS equals popped value; push plus pop -> occupancy unchanged.
REQ-036 SHALL cover: I_ENABLE=0 with write, push and request -> no state change, no O_COND_VALID; I_RESET pulsed between clock edges -> all outputs to reset values at once.
